// File: rtl/alu_mc_if.sv
// alu_mc_if: request/response bundle for the multi-cycle ALU.
//   Request side : valid_i, ready_o, op_i[2:0], src1_i, src2_i
//   Response side: valid_o, ready_i, result_o, busy_o
//   slave  modport - the ALU itself
//   master modport - the issuing/consuming agent
interface alu_mc_if #(
  parameter int WIDTH = 32
);
  logic             valid_i;
  logic             ready_o;
  logic [2:0]       op_i;
  logic [WIDTH-1:0] src1_i;
  logic [WIDTH-1:0] src2_i;
  logic             valid_o;
  logic             ready_i;
  logic [WIDTH-1:0] result_o;
  logic             busy_o;

  modport slave (
    input  valid_i, op_i, src1_i, src2_i, ready_i,
    output ready_o, valid_o, result_o, busy_o
  );

  modport master (
    output valid_i, op_i, src1_i, src2_i, ready_i,
    input  ready_o, valid_o, result_o, busy_o
  );
endinterface

// File: rtl/alu_mc.sv
// alu_mc: multi-cycle ALU with registered result and valid/ready handshakes.
//   clk_i  - clock, rising edge
//   rst_i  - asynchronous active-low reset
//   bus    - alu_mc_if.slave: request (valid_i/ready_o/op_i/src1_i/src2_i),
//            response (valid_o/ready_i/result_o), busy_o (multiply running)
// Ops: 000 AND, 001 XOR, 010 SLL, 011 ADD, 100 SUB, 101 MUL (low half),
//      110 ADD, 111 SRA. One request in flight; MUL is iterative shift-add.
// Build option: ALU_RADIX4_MUL_EN retires 2 multiplier bits per edge
// (MUL latency WIDTH/2 instead of WIDTH); results are identical.
module alu_mc #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input logic     clk_i,
  input logic     rst_i,
  alu_mc_if.slave bus
);

`ifdef ALU_RADIX4_MUL_EN
  localparam int STEP = 2;
`else
  localparam int STEP = 1;
`endif
  // The accept edge already performs the first iteration, so the counter
  // covers the remaining WIDTH/STEP-1 edges spent in S_MUL.
  localparam logic [SHW-1:0] CNT_INIT = SHW'(WIDTH / STEP - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_result, w_result_nxt;
  logic [WIDTH-1:0] r_mcand, w_mcand_nxt;
  logic [WIDTH-1:0] r_mplier, w_mplier_nxt;
  logic [WIDTH-1:0] r_acc, w_acc_nxt;
  logic [SHW-1:0]   r_cnt, w_cnt_nxt;

  logic [WIDTH-1:0] w_alu;
  logic [SHW-1:0]   w_shamt;
  logic [WIDTH-1:0] w_mc_in, w_mp_in, w_acc_in, w_pp;
  logic [WIDTH-1:0] w_mc_step, w_mp_step, w_acc_step;
  logic             w_ready, w_valid, w_busy;

  // Single-cycle operations
  always_comb begin
    w_shamt = bus.src2_i[SHW-1:0];
    w_alu   = '0;
    case (bus.op_i)
      3'b000:         w_alu = bus.src1_i & bus.src2_i;
      3'b001:         w_alu = bus.src1_i ^ bus.src2_i;
      3'b010:         w_alu = bus.src1_i << w_shamt;
      3'b011, 3'b110: w_alu = bus.src1_i + bus.src2_i;
      3'b100:         w_alu = bus.src1_i - bus.src2_i;
      3'b111:         w_alu = $signed(bus.src1_i) >>> w_shamt;
      default:        w_alu = '0;
    endcase
  end

  // One shift-add iteration; in IDLE it runs on the incoming operands so the
  // accept edge doubles as the first multiply step.
  always_comb begin
    w_mc_in  = (r_state == S_IDLE) ? bus.src1_i : r_mcand;
    w_mp_in  = (r_state == S_IDLE) ? bus.src2_i : r_mplier;
    w_acc_in = (r_state == S_IDLE) ? '0         : r_acc;
    w_pp     = '0;
`ifdef ALU_RADIX4_MUL_EN
    case (w_mp_in[1:0])
      2'b01:   w_pp = w_mc_in;
      2'b10:   w_pp = w_mc_in << 1;
      2'b11:   w_pp = w_mc_in + (w_mc_in << 1);
      default: w_pp = '0;
    endcase
    w_mc_step = w_mc_in << 2;
    w_mp_step = w_mp_in >> 2;
`else
    if (w_mp_in[0]) w_pp = w_mc_in;
    w_mc_step = w_mc_in << 1;
    w_mp_step = w_mp_in >> 1;
`endif
    w_acc_step = w_acc_in + w_pp;
  end

  // Next-state and output decode
  always_comb begin
    w_state_nxt  = r_state;
    w_result_nxt = r_result;
    w_mcand_nxt  = r_mcand;
    w_mplier_nxt = r_mplier;
    w_acc_nxt    = r_acc;
    w_cnt_nxt    = r_cnt;
    w_ready      = 1'b0;
    w_valid      = 1'b0;
    w_busy       = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_ready = 1'b1;
        if (bus.valid_i) begin
          if (bus.op_i == 3'b101) begin
            w_mcand_nxt  = w_mc_step;
            w_mplier_nxt = w_mp_step;
            w_acc_nxt    = w_acc_step;
            w_cnt_nxt    = CNT_INIT;
            w_state_nxt  = S_MUL;
          end else begin
            w_result_nxt = w_alu;
            w_state_nxt  = S_DONE;
          end
        end
      end
      S_MUL: begin
        w_busy       = 1'b1;
        w_mcand_nxt  = w_mc_step;
        w_mplier_nxt = w_mp_step;
        w_acc_nxt    = w_acc_step;
        w_cnt_nxt    = r_cnt - SHW'(1);
        if (r_cnt == SHW'(1)) begin
          w_result_nxt = w_acc_step;
          w_state_nxt  = S_DONE;
        end
      end
      S_DONE: begin
        w_valid = 1'b1;
        if (bus.ready_i) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state  <= S_IDLE;
      r_result <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_result <= w_result_nxt;
      r_mcand  <= w_mcand_nxt;
      r_mplier <= w_mplier_nxt;
      r_acc    <= w_acc_nxt;
      r_cnt    <= w_cnt_nxt;
    end
  end

  assign bus.ready_o  = w_ready;
  assign bus.valid_o  = w_valid;
  assign bus.busy_o   = w_busy;
  assign bus.result_o = r_result;

endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: self-checking bench for alu_mc (WIDTH=32).
// Directed vector table, hand-written multiply/backpressure/reset sequences,
// and a randomized stream checked against an arithmetic reference model.
module tb_alu_mc;
  localparam int W = 32;
`ifdef ALU_RADIX4_MUL_EN
  localparam int MUL_LAT = W / 2;
`else
  localparam int MUL_LAT = W;
`endif
  localparam int NR = 120;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  alu_mc_if #(.WIDTH(W)) bus();

  alu_mc #(.WIDTH(W)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [4:0] sh;
    sh = b[4:0];
    case (op)
      3'd0:       return a & b;
      3'd1:       return a ^ b;
      3'd2:       return a << sh;
      3'd3, 3'd6: return a + b;
      3'd4:       return a - b;
      3'd5:       return a * b;
      default:    return $signed(a) >>> sh;
    endcase
  endfunction

  // Called at a negedge; returns at the negedge after the accept edge.
  task automatic launch(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    int g = 0;
    while (!bus.ready_o && g < 100) begin
      @(negedge clk);
      g++;
    end
    chk("launch_ready", {31'b0, bus.ready_o}, 32'd1);
    bus.valid_i = 1'b1;
    bus.op_i    = op;
    bus.src1_i  = a;
    bus.src2_i  = b;
    @(negedge clk);
    bus.valid_i = 1'b0;
    bus.op_i    = 3'($urandom);
    bus.src1_i  = $urandom;
    bus.src2_i  = $urandom;
  endtask

  task automatic wait_valid(output int lat);
    lat = 1;
    while (!bus.valid_o && lat < 200) begin
      @(negedge clk);
      lat++;
    end
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    int          lat;
  } vec_t;

  vec_t vecs[13];

  initial begin
    int lat;
    logic [31:0] r;
    logic [31:0] expq[$];
    int sent, got, cyc;
    bit take;

    vecs[0]  = '{3'b011, 32'd5,          32'd7,          32'd12,         1};
    vecs[1]  = '{3'b100, 32'd3,          32'd5,          32'hFFFF_FFFE,  1};
    vecs[2]  = '{3'b111, 32'h8000_0000,  32'd4,          32'hF800_0000,  1};
    vecs[3]  = '{3'b010, 32'd1,          32'd33,         32'h0000_0002,  1};
    vecs[4]  = '{3'b101, 32'hFFFF_FFFF,  32'd3,          32'hFFFF_FFFD,  MUL_LAT};
    vecs[5]  = '{3'b000, 32'hF0F0_F0F0,  32'hFF00_FF00,  32'hF000_F000,  1};
    vecs[6]  = '{3'b001, 32'hF0F0_F0F0,  32'hFF00_FF00,  32'h0FF0_0FF0,  1};
    vecs[7]  = '{3'b110, 32'hFFFF_FFFF,  32'd2,          32'h0000_0001,  1};
    vecs[8]  = '{3'b101, 32'd7,          32'd6,          32'h0000_002A,  MUL_LAT};
    vecs[9]  = '{3'b101, 32'h0001_0000,  32'h0001_0000,  32'h0000_0000,  MUL_LAT};
    vecs[10] = '{3'b111, 32'h7FFF_FFF0,  32'd4,          32'h07FF_FFFF,  1};
    vecs[11] = '{3'b010, 32'd3,          32'd31,         32'h8000_0000,  1};
    vecs[12] = '{3'b111, 32'h8000_0001,  32'h0000_003F,  32'hFFFF_FFFF,  1};

    bus.valid_i = 1'b0;
    bus.ready_i = 1'b0;
    bus.op_i    = 'x;
    bus.src1_i  = '0;
    bus.src2_i  = '0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_ready_o",  {31'b0, bus.ready_o}, 32'd1);
    chk("rst_valid_o",  {31'b0, bus.valid_o}, 32'd0);
    chk("rst_busy_o",   {31'b0, bus.busy_o},  32'd0);
    chk("rst_result_o", bus.result_o,         32'd0);
    rst = 1'b1;
    @(negedge clk);

    // Directed table
    for (int i = 0; i < 13; i++) begin
      launch(vecs[i].op, vecs[i].a, vecs[i].b);
      wait_valid(lat);
      chk($sformatf("vec%0d_result", i), bus.result_o, vecs[i].res);
      chk($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
      bus.ready_i = 1'b1;
      @(negedge clk);
      bus.ready_i = 1'b0;
      chk($sformatf("vec%0d_ready_after", i), {31'b0, bus.ready_o}, 32'd1);
      chk($sformatf("vec%0d_valid_after", i), {31'b0, bus.valid_o}, 32'd0);
    end

    // MUL with busy_o tracking and ignored valid_i pulses
    launch(3'b101, 32'hFFFF_FFFF, 32'd3);
    lat = 1;
    while (!bus.valid_o && lat < 200) begin
      chk("mul_busy",  {31'b0, bus.busy_o},  32'd1);
      chk("mul_ready", {31'b0, bus.ready_o}, 32'd0);
      bus.valid_i = lat[0];
      bus.op_i    = 3'b011;
      bus.src1_i  = $urandom;
      bus.src2_i  = $urandom;
      @(negedge clk);
      lat++;
    end
    bus.valid_i = 1'b0;
    chk("mul_latency",     lat, MUL_LAT);
    chk("mul_result",      bus.result_o, 32'hFFFF_FFFD);
    chk("mul_busy_done",   {31'b0, bus.busy_o}, 32'd0);
    bus.ready_i = 1'b1;
    @(negedge clk);
    bus.ready_i = 1'b0;
    @(negedge clk);
    chk("mul_no_extra_valid", {31'b0, bus.valid_o}, 32'd0);
    chk("mul_idle_ready",     {31'b0, bus.ready_o}, 32'd1);

    // Backpressure
    launch(3'b011, 32'd9, 32'd10);
    wait_valid(lat);
    chk("bp_latency", lat, 1);
    for (int k = 0; k < 5; k++) begin
      chk("bp_valid_hold",  {31'b0, bus.valid_o}, 32'd1);
      chk("bp_result_hold", bus.result_o, 32'd19);
      chk("bp_ready_low",   {31'b0, bus.ready_o}, 32'd0);
      @(negedge clk);
    end
    bus.ready_i = 1'b1;
    @(negedge clk);
    bus.ready_i = 1'b0;
    chk("bp_valid_drop", {31'b0, bus.valid_o}, 32'd0);
    chk("bp_ready_back", {31'b0, bus.ready_o}, 32'd1);

    // Asynchronous reset at MUL edge 10 (accept edge is edge 1)
    launch(3'b101, 32'h1234_5678, 32'd9);
    repeat (8) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("arst_ready_o",  {31'b0, bus.ready_o}, 32'd1);
    chk("arst_valid_o",  {31'b0, bus.valid_o}, 32'd0);
    chk("arst_busy_o",   {31'b0, bus.busy_o},  32'd0);
    chk("arst_result_o", bus.result_o,         32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    launch(3'b011, 32'd1, 32'd1);
    wait_valid(lat);
    chk("post_rst_add", bus.result_o, 32'd2);
    chk("post_rst_lat", lat, 1);
    bus.ready_i = 1'b1;
    @(negedge clk);
    bus.ready_i = 1'b0;

    // Random stream with random consumer stalls
    sent = 0;
    got  = 0;
    cyc  = 0;
    take = 1'b0;
    while (got < NR && cyc < 30000) begin
      @(negedge clk);
      cyc++;
      if (take) begin
        bus.valid_i = 1'b0;
        bus.op_i    = 'x;
        take        = 1'b0;
      end
      if (!bus.valid_i && sent < NR && $urandom_range(0, 3) != 0) begin
        bus.valid_i = 1'b1;
        bus.op_i    = 3'($urandom_range(0, 7));
        bus.src1_i  = $urandom;
        bus.src2_i  = $urandom;
      end
      bus.ready_i = ($urandom_range(0, 2) != 0);
      if (bus.valid_i && bus.ready_o) begin
        expq.push_back(model(bus.op_i, bus.src1_i, bus.src2_i));
        sent++;
        take = 1'b1;
      end
      if (bus.valid_o && bus.ready_i) begin
        got++;
        if (expq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rand_unexpected result=%h required=none", bus.result_o);
        end else begin
          r = expq.pop_front();
          chk($sformatf("rand_result%0d", got), bus.result_o, r);
        end
      end
    end
    @(negedge clk);
    bus.valid_i = 1'b0;
    bus.ready_i = 1'b0;
    chk("rand_count",    got, NR);
    chk("rand_leftover", expq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
